// File: rtl/tl45_opfetch.sv
// TL45 operand-fetch stage: register file, priority forwarding, load-use
// bubbles and the registered operand bundle handed to the ALU stage.
module tl45_opfetch #(
   parameter int NREGS = 16,
   parameter int XLEN  = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_pipe_stall,
   output logic            o_pipe_stall,
   input  logic            i_pipe_flush,
   output logic            o_pipe_flush,
   input  logic [4:0]      i_opcode,
   input  logic [3:0]      i_dr,
   input  logic [3:0]      i_sr1,
   input  logic [3:0]      i_sr2,
   input  logic [XLEN-1:0] i_imm,
   input  logic            i_imm_valid,
   input  logic [3:0]      i_jmp_cond,
   input  logic [XLEN-1:0] i_pc,
   input  logic [3:0]      i_alu_of_reg,
   input  logic [XLEN-1:0] i_alu_of_val,
   input  logic [3:0]      i_mem_of_reg,
   input  logic [XLEN-1:0] i_mem_of_val,
   input  logic [3:0]      i_mem_pending_reg,
   input  logic [3:0]      i_wb_reg,
   input  logic [XLEN-1:0] i_wb_val,
   output logic [4:0]      o_opcode,
   output logic [3:0]      o_dr,
   output logic [3:0]      o_jmp_cond,
   output logic [XLEN-1:0] o_sr1_val,
   output logic [XLEN-1:0] o_sr2_val,
   output logic [XLEN-1:0] o_target_offset,
   output logic [XLEN-1:0] o_pc
);

   // Pipeline contract: an instruction moves into the ALU only when neither
   // i_pipe_stall nor hazard is high; a flush zeroes the bundle and wins over
   // stall; decode holds its instruction whenever o_pipe_stall is high.

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] sr1_res;
   logic [XLEN-1:0] sr2_res;
   logic [XLEN-1:0] sr2_sel;
   logic            hazard;

   // Youngest producer wins: ALU, then memory, then the in-flight writeback.
   function automatic logic [XLEN-1:0] resolve(
      input logic [3:0]      src,
      input logic [XLEN-1:0] rf_val,
      input logic [3:0]      alu_reg,
      input logic [XLEN-1:0] alu_val,
      input logic [3:0]      mem_reg,
      input logic [XLEN-1:0] mem_val,
      input logic [3:0]      wb_reg,
      input logic [XLEN-1:0] wb_val
   );
      if (src == 4'd0)          return '0;
      else if (src == alu_reg)  return alu_val;
      else if (src == mem_reg)  return mem_val;
      else if (src == wb_reg)   return wb_val;
      else                      return rf_val;
   endfunction

   always_comb begin
      sr1_res = resolve(i_sr1, regs[i_sr1], i_alu_of_reg, i_alu_of_val,
                        i_mem_of_reg, i_mem_of_val, i_wb_reg, i_wb_val);
      sr2_res = resolve(i_sr2, regs[i_sr2], i_alu_of_reg, i_alu_of_val,
                        i_mem_of_reg, i_mem_of_val, i_wb_reg, i_wb_val);
      sr2_sel = i_imm_valid ? i_imm : sr2_res;
   end

   always_comb begin
      hazard = (i_mem_pending_reg != 4'd0) && (i_opcode != 5'd0) &&
               ((i_sr1 == i_mem_pending_reg) ||
                (!i_imm_valid && (i_sr2 == i_mem_pending_reg)));
   end

   assign o_pipe_stall = i_pipe_stall || hazard;
   assign o_pipe_flush = i_pipe_flush;

   // Writeback is independent of stall/flush so retiring results never drop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (i_wb_reg != 4'd0) begin
         regs[i_wb_reg] <= i_wb_val;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_pipe_flush || (!i_pipe_stall && hazard)) begin
         o_opcode        <= '0;
         o_dr            <= '0;
         o_jmp_cond      <= '0;
         o_sr1_val       <= '0;
         o_sr2_val       <= '0;
         o_target_offset <= '0;
         o_pc            <= '0;
      end else if (!i_pipe_stall) begin
         o_opcode        <= i_opcode;
         o_dr            <= i_dr;
         o_jmp_cond      <= i_jmp_cond;
         o_sr1_val       <= sr1_res;
         o_sr2_val       <= sr2_sel;
         o_target_offset <= i_imm;
         o_pc            <= i_pc;
      end
   end

endmodule

// File: tb/tb_tl45_opfetch.sv
// Bench for tl45_opfetch: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage.
module tb_tl45_opfetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pipe_stall = 1'b0, pipe_flush = 1'b0;
   logic        o_pipe_stall, o_pipe_flush;
   logic [4:0]  opcode = '0;
   logic [3:0]  dr = '0, sr1 = '0, sr2 = '0, jmp_cond = '0;
   logic [31:0] imm = '0, pc = '0;
   logic        imm_valid = 1'b0;
   logic [3:0]  alu_reg = '0, mem_reg = '0, pend_reg = '0, wb_reg = '0;
   logic [31:0] alu_val = '0, mem_val = '0, wb_val = '0;
   logic [4:0]  o_opcode;
   logic [3:0]  o_dr, o_jmp_cond;
   logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

   int n_vec = 0;
   int n_err = 0;

   // model state: architectural registers and expected output bundle
   logic [31:0] m_regs [16];
   logic [31:0] e_bundle [7];

   tl45_opfetch dut (
      .i_clk(clk), .i_reset(rst),
      .i_pipe_stall(pipe_stall), .o_pipe_stall(o_pipe_stall),
      .i_pipe_flush(pipe_flush), .o_pipe_flush(o_pipe_flush),
      .i_opcode(opcode), .i_dr(dr), .i_sr1(sr1), .i_sr2(sr2),
      .i_imm(imm), .i_imm_valid(imm_valid), .i_jmp_cond(jmp_cond), .i_pc(pc),
      .i_alu_of_reg(alu_reg), .i_alu_of_val(alu_val),
      .i_mem_of_reg(mem_reg), .i_mem_of_val(mem_val),
      .i_mem_pending_reg(pend_reg),
      .i_wb_reg(wb_reg), .i_wb_val(wb_val),
      .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
      .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
      .o_target_offset(o_target_offset), .o_pc(o_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // value a source register holds right now, seen from the fetch stage
   function automatic logic [31:0] model_read(input logic [3:0] src);
      logic [3:0]  who  [3];
      logic [31:0] what [3];
      if (src == 0) return 0;
      who[0] = alu_reg; what[0] = alu_val;
      who[1] = mem_reg; what[1] = mem_val;
      who[2] = wb_reg;  what[2] = wb_val;
      for (int k = 0; k < 3; k++)
         if (who[k] == src) return what[k];
      return m_regs[src];
   endfunction

   task automatic step();
      logic        bubble;
      logic [31:0] nxt [7];
      #1;
      bubble = opcode != 0 && pend_reg != 0 &&
               (sr1 == pend_reg || (!imm_valid && sr2 == pend_reg));
      check("pipe_stall", {31'd0, o_pipe_stall}, {31'd0, pipe_stall | bubble});
      check("pipe_flush", {31'd0, o_pipe_flush}, {31'd0, pipe_flush});
      nxt[0] = {27'd0, opcode};  nxt[1] = {28'd0, dr};  nxt[2] = {28'd0, jmp_cond};
      nxt[3] = model_read(sr1);
      nxt[4] = imm_valid ? imm : model_read(sr2);
      nxt[5] = imm;  nxt[6] = pc;
      @(posedge clk);
      if (rst || pipe_flush || (!pipe_stall && bubble))
         for (int k = 0; k < 7; k++) e_bundle[k] = 0;
      else if (!pipe_stall)
         for (int k = 0; k < 7; k++) e_bundle[k] = nxt[k];
      if (rst) for (int k = 0; k < 16; k++) m_regs[k] = 0;
      else if (wb_reg != 0) m_regs[wb_reg] = wb_val;
      #1;
      check("opcode", {27'd0, o_opcode}, e_bundle[0]);
      check("dr", {28'd0, o_dr}, e_bundle[1]);
      check("jmp_cond", {28'd0, o_jmp_cond}, e_bundle[2]);
      check("sr1_val", o_sr1_val, e_bundle[3]);
      check("sr2_val", o_sr2_val, e_bundle[4]);
      check("target_offset", o_target_offset, e_bundle[5]);
      check("pc", o_pc, e_bundle[6]);
   endtask

   task automatic idle();
      rst = 0; pipe_stall = 0; pipe_flush = 0; opcode = 0; dr = 0; sr1 = 0; sr2 = 0;
      imm = 0; imm_valid = 0; jmp_cond = 0; pc = 0; alu_reg = 0; alu_val = 0;
      mem_reg = 0; mem_val = 0; pend_reg = 0; wb_reg = 0; wb_val = 0;
   endtask

   task automatic instr(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [31:0] p);
      opcode = op; dr = d; sr1 = s1; sr2 = s2; pc = p;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) m_regs[k] = 0;
      for (int k = 0; k < 7; k++) e_bundle[k] = 0;

      // reset
      rst = 1; opcode = 5'd9; pc = 32'h40;
      step(); step();
      check("rst_opcode", {27'd0, o_opcode}, 32'd0);
      check("rst_pc", o_pc, 32'd0);

      // write r3 via wb, then ADD r4 = r3 + r3
      idle(); wb_reg = 3; wb_val = 32'h11; step();
      idle(); instr(5'd1, 4'd4, 4'd3, 4'd3, 32'h100); step();
      check("add_sr1", o_sr1_val, 32'h11);
      check("add_sr2", o_sr2_val, 32'h11);
      check("add_opcode", {27'd0, o_opcode}, 32'd1);
      check("add_dr", {28'd0, o_dr}, 32'd4);

      // forwarding priority on r5
      idle(); wb_reg = 5; wb_val = 32'd1; step();
      idle(); instr(5'd1, 4'd1, 4'd5, 4'd0, 32'h104);
      wb_reg = 5; wb_val = 32'd2; mem_reg = 5; mem_val = 32'd3; alu_reg = 5; alu_val = 32'd4;
      step(); check("fwd_alu", o_sr1_val, 32'd4);
      alu_reg = 0; step(); check("fwd_mem", o_sr1_val, 32'd3);
      mem_reg = 0; step(); check("fwd_wb", o_sr1_val, 32'd2);

      // r0 always reads zero, writes to it are dropped
      idle(); instr(5'd1, 4'd2, 4'd0, 4'd0, 32'h108);
      alu_reg = 0; alu_val = 32'hDEAD; wb_reg = 0; wb_val = 32'h99;
      step(); check("r0_read", o_sr1_val, 32'd0);
      step(); check("r0_after_wb", o_sr2_val, 32'd0);

      // stall holds a captured SUB while its source is rewritten
      idle(); instr(5'd2, 4'd6, 4'd3, 4'd5, 32'h10C); jmp_cond = 4'd3; step();
      check("sub_sr2", o_sr2_val, 32'd2);
      pipe_stall = 1;
      for (int c = 0; c < 3; c++) begin
         wb_reg = 3; wb_val = 32'h70 + c; step();
         check("stall_out", {31'd0, o_pipe_stall}, 32'd1);
         check("stall_hold_sr1", o_sr1_val, 32'h11);
         check("stall_hold_pc", o_pc, 32'h10C);
      end

      // load-use bubble on r7, then released with memory forwarding
      idle(); instr(5'd1, 4'd8, 4'd7, 4'd3, 32'h110); pend_reg = 7;
      for (int c = 0; c < 2; c++) begin
         step();
         check("lu_stall", {31'd0, o_pipe_stall}, 32'd1);
         check("lu_bubble", {27'd0, o_opcode}, 32'd0);
      end
      pend_reg = 0; mem_reg = 7; mem_val = 32'h55; step();
      check("lu_release", o_sr1_val, 32'h55);

      // flush wins over stall; then immediate operand
      idle(); instr(5'd3, 4'd9, 4'd3, 4'd3, 32'h114); pipe_flush = 1; pipe_stall = 1; step();
      check("flush_out", {31'd0, o_pipe_flush}, 32'd1);
      check("flush_opcode", {27'd0, o_opcode}, 32'd0);
      check("flush_sr1", o_sr1_val, 32'd0);
      idle(); instr(5'd4, 4'd9, 4'd3, 4'd7, 32'h118); imm_valid = 1; imm = 32'hFFFF_FFFC;
      pend_reg = 7; step();
      check("imm_sr2", o_sr2_val, 32'hFFFF_FFFC);
      check("imm_offset", o_target_offset, 32'hFFFF_FFFC);

      // random traffic on a narrow register window to provoke overlaps
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 99) == 0);
         pipe_stall = ($urandom_range(0, 5) == 0);
         pipe_flush = ($urandom_range(0, 9) == 0);
         opcode     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         dr = 4'($urandom); sr1 = 4'($urandom_range(0, 7)); sr2 = 4'($urandom_range(0, 7));
         jmp_cond = 4'($urandom); imm = $urandom; imm_valid = 1'($urandom); pc = $urandom;
         alu_reg  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
         mem_reg  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
         pend_reg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
         wb_reg   = 4'($urandom_range(0, 7));
         alu_val = $urandom; mem_val = $urandom; wb_val = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tl45_opfetch.md
Name: tl45_opfetch

Overview:
Operand-fetch stage of the TL45 pipeline. It sits between decode and the ALU/branch stage. It holds the 16x32 register file and reads source operands, applying priority forwarding from the ALU, memory and writeback stages. It inserts bubbles on load-use hazards and registers the operand bundle consumed by the ALU. It implements the upstream side of the ALU stall/flush contract:
- outputs are zero in the cycle after a flush;
- outputs are held while the downstream stage stalls.

Parameters:
NREGS, 16, number of architectural registers (r0 reads as zero, writes to r0 are ignored)
XLEN, 32, datapath width

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-high reset
i_pipe_stall  input  1  stall from ALU stage
o_pipe_stall  output  1  stall to decode
i_pipe_flush  input  1  flush from ALU stage (taken branch)
o_pipe_flush  output  1  flush forwarded to decode; equals i_pipe_flush
i_opcode  input  5  decoded opcode (0 = NOP)
i_dr  input  4  destination register
i_sr1  input  4  source register 1 index
i_sr2  input  4  source register 2 index
i_imm  input  32  sign-extended immediate / branch offset
i_imm_valid  input  1  1: sr2 operand is i_imm instead of reg[i_sr2]
i_jmp_cond  input  4  branch condition code
i_pc  input  32  instruction PC
i_alu_of_reg  input  4  ALU forward register (0 = none), combinational from ALU
i_alu_of_val  input  32  ALU forward value
i_mem_of_reg  input  4  memory-stage forward register (0 = none)
i_mem_of_val  input  32  memory-stage forward value
i_mem_pending_reg  input  4  destination of a load whose data is not yet available (0 = none)
i_wb_reg  input  4  writeback register (0 = no write)
i_wb_val  input  32  writeback value
o_opcode  output  5  registered opcode to ALU
o_dr  output  4  registered destination
o_jmp_cond  output  4  registered condition
o_sr1_val  output  32  registered operand 1
o_sr2_val  output  32  registered operand 2
o_target_offset  output  32  registered i_imm
o_pc  output  32  registered PC

Behaviour:
- Reset: all o_* registers cleared to 0; all register-file entries cleared to 0.
- Register file:
  - one synchronous write port: if i_wb_reg != 0, then reg[i_wb_reg] <= i_wb_val on posedge;
  - writes occur regardless of stall or flush, and are blocked only by reset.
- Operand resolve (combinational), for src in {sr1, sr2}:
  - src == 0 -> 0;
  - else if src == i_alu_of_reg -> i_alu_of_val;
  - else if src == i_mem_of_reg -> i_mem_of_val;
  - else if src == i_wb_reg -> i_wb_val (write-through bypass);
  - else reg[src].
- Operand 2 source: sr2 value = i_imm_valid ? i_imm : resolved sr2.
- Hazard (combinational): hazard = (i_mem_pending_reg != 0) && (i_sr1 == i_mem_pending_reg || (!i_imm_valid && i_sr2 == i_mem_pending_reg)) && (i_opcode != 0).
- Stall/flush outputs:
  - o_pipe_stall = i_pipe_stall || hazard;
  - o_pipe_flush = i_pipe_flush.
- Output register update on posedge, in priority order:
  1. i_reset or i_pipe_flush -> all outputs 0 (NOP bubble).
  2. else i_pipe_stall -> all outputs hold.
  3. else hazard -> all outputs 0 (bubble); decode holds because o_pipe_stall = 1.
  4. else capture: opcode, dr, jmp_cond, pc, resolved operands, target_offset = i_imm.
- Latency: 1 cycle from input to registered output when unstalled.
- Stall-hold correctness: held operands were resolved at capture time and are never re-read, so writebacks during a stall do not alter them.
- Simultaneous events:
  - flush + stall -> flush wins (outputs 0);
  - flush + hazard -> outputs 0, and o_pipe_stall is still driven by hazard;
  - i_wb_reg == i_alu_of_reg == src -> ALU value used.
- A hazard bubble repeats each cycle until i_mem_pending_reg no longer matches. The instruction is then captured with i_mem_of forwarding.
- NOP input (opcode 0) never raises hazard.

Test Plan:
- Reset, then write r3=0x11 via wb; next cycle decode ADD dr=4 sr1=3 sr2=3 -> o_sr1_val=o_sr2_val=0x11, o_opcode=1, o_dr=4 one cycle later.
- Forward priority: reg r5=1, i_wb_reg=5/val 2, i_mem_of 5/3, i_alu_of 5/4 -> o_sr1_val=4; drop ALU forward -> 3; drop mem forward -> 2.
- r0 reads: sr1=0 with i_alu_of_reg=0, i_alu_of_val=0xDEAD -> o_sr1_val=0; wb to r0 is ignored.
- Stall: capture SUB, then i_pipe_stall=1 for 3 cycles while wb changes the source register -> outputs unchanged for all 3 cycles, o_pipe_stall=1.
- Load-use: i_mem_pending_reg=7, decode sr1=7 -> o_pipe_stall=1, outputs 0 for 2 cycles; then pending=0 with i_mem_of 7/0x55 -> o_sr1_val=0x55.
- Flush: i_pipe_flush=1 with a valid instruction and i_pipe_stall=1 -> next cycle all outputs 0, o_pipe_flush=1; i_imm_valid=1 with imm 0xFFFFFFFC -> o_sr2_val=o_target_offset=0xFFFFFFFC.
